// File: rtl/i2c_slave_rx.sv
// I2C target receive engine: synchronises SCL/SDA, detects START/STOP, deserialises write bytes MSB-first, drives ACK/NACK.
// Write transfers only; read requests and foreign addresses are NACKed and ignored until START or STOP.
module i2c_slave_rx #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h48,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       scl_in,
    input  logic       sda_in,
    input  logic       ack_enable,
    output logic       sda_drive_low,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_match,
    output logic       start_det,
    output logic       stop_det,
    output logic       overflow
);

    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE} state_t;

    logic [SYNC_STAGES-1:0] scl_ff, sda_ff;
    logic                   scl_d, sda_d;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, sda_rise, sda_fall;
    logic                   start_cond, stop_cond;

    // Synchronisers preset high so reset looks like an idle bus.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            scl_ff <= '1;
            sda_ff <= '1;
            scl_d  <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_ff <= {scl_ff[SYNC_STAGES-2:0], scl_in};
            sda_ff <= {sda_ff[SYNC_STAGES-2:0], sda_in};
            scl_d  <= scl_s;
            sda_d  <= sda_s;
        end
    end

    assign scl_s    = scl_ff[SYNC_STAGES-1];
    assign sda_s    = sda_ff[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    assign sda_rise = sda_s & ~sda_d;
    assign sda_fall = ~sda_s & sda_d;
    // SCL must have been high in the prior cycle too, so an SDA edge coincident with scl_rise is data.
    assign start_cond = sda_fall & scl_s & scl_d;
    assign stop_cond  = sda_rise & scl_s & scl_d;

    state_t      state, state_n;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic [7:0]  shift, shift_n, shifted;
    logic        ack_cap, ack_cap_n;
    logic        drive_n;
    logic [7:0]  rx_data_n;
    logic        rx_valid_n, addr_match_n, start_det_n, stop_det_n, overflow_n;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shift         <= '0;
            ack_cap       <= 1'b0;
            sda_drive_low <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            addr_match    <= 1'b0;
            start_det     <= 1'b0;
            stop_det      <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            state         <= state_n;
            bit_cnt       <= bit_cnt_n;
            shift         <= shift_n;
            ack_cap       <= ack_cap_n;
            sda_drive_low <= drive_n;
            rx_data       <= rx_data_n;
            rx_valid      <= rx_valid_n;
            addr_match    <= addr_match_n;
            start_det     <= start_det_n;
            stop_det      <= stop_det_n;
            overflow      <= overflow_n;
        end
    end

    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift;
        ack_cap_n    = ack_cap;
        drive_n      = sda_drive_low;
        rx_data_n    = rx_data;
        rx_valid_n   = 1'b0;
        addr_match_n = addr_match;
        start_det_n  = 1'b0;
        stop_det_n   = 1'b0;
        overflow_n   = overflow;
        shifted      = {shift[6:0], sda_s};

        if (start_cond) begin
            state_n      = ADDR;
            bit_cnt_n    = '0;
            shift_n      = '0;
            drive_n      = 1'b0;
            addr_match_n = 1'b0;
            overflow_n   = 1'b0;
            start_det_n  = 1'b1;
        end else if (stop_cond) begin
            state_n      = IDLE;
            drive_n      = 1'b0;
            addr_match_n = 1'b0;
            stop_det_n   = 1'b1;
        end else begin
            if (scl_rise && state != IDLE && state != IGNORE) begin
                shift_n   = shifted;
                bit_cnt_n = bit_cnt + 4'd1;
            end
            case (state)
                ADDR: begin
                    if (scl_rise && bit_cnt == 4'd7) begin
                        if (shifted[7:1] != SLAVE_ADDR || shifted[0])
                            state_n = IGNORE;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        drive_n      = 1'b1;
                        addr_match_n = 1'b1;
                        state_n      = ADDR_ACK;
                    end
                end
                ADDR_ACK, DATA_ACK: begin
                    if (scl_fall) begin
                        drive_n   = 1'b0;
                        bit_cnt_n = '0;
                        state_n   = DATA;
                    end
                end
                DATA: begin
                    if (scl_rise && bit_cnt == 4'd7) begin
                        rx_data_n  = shifted;
                        rx_valid_n = 1'b1;
                        ack_cap_n  = ack_enable;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        drive_n = ack_cap;
                        if (!ack_cap)
                            overflow_n = 1'b1;
                        state_n = DATA_ACK;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
